// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared constants and types for the pipeline hazard controller.
// TUSE_NONE, mult/div cycle defaults, MD timer state encoding.
package pipe_hazard_ctrl_pkg;

  localparam logic [1:0] TUSE_NONE = 2'd3;
  localparam int MULT_CYC_DEF = 5;
  localparam int DIV_CYC_DEF  = 10;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } md_state_e;

  function automatic logic raw_hit(
    input logic [4:0] a,
    input logic [1:0] tuse,
    input logic [4:0] ea,
    input logic [1:0] et,
    input logic [4:0] ma,
    input logic [1:0] mt
  );
    return (a != 5'd0) &&
      (((a == ea) && (et > tuse)) ||
       ((a == ma) && (mt > tuse)));
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_md_busy_timer.sv
// Mult/div busy timer: start_i/div_i/kill_i in, busy_o/done_o out.
// Loads cycle count on start, counts down, done_o on the last cycle.
module pipe_hazard_ctrl_md_busy_timer
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int MULT_CYC = MULT_CYC_DEF,
  parameter int DIV_CYC  = DIV_CYC_DEF,
  parameter int CNT_W    = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start_i,
  input  logic div_i,
  input  logic kill_i,
  output logic busy_o,
  output logic done_o
);

  localparam logic [CNT_W-1:0] MULT_LD = CNT_W'(MULT_CYC);
  localparam logic [CNT_W-1:0] DIV_LD  = CNT_W'(DIV_CYC);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_o  = 1'b0;
    busy_o  = 1'b0;
    unique case (state_q)
      IDLE: begin
        // a start cancelled by an exception never launches
        if (start_i && !kill_i) begin
          cnt_d   = div_i ? DIV_LD : MULT_LD;
          state_d = BUSY;
        end
      end
      BUSY: begin
        busy_o = 1'b1;
        cnt_d  = cnt_q - ONE;
        if (cnt_q == ONE) begin
          done_o  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: hazard inputs in,
// pc_en/fd_wren/de_stall/req, md_busy/md_done, stall_cnt out.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int MULT_CYC = MULT_CYC_DEF,
  parameter int DIV_CYC  = DIV_CYC_DEF,
  parameter int CNT_W    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  D_rs_addr,
  input  logic [4:0]  D_rt_addr,
  input  logic [1:0]  D_rs_tuse,
  input  logic [1:0]  D_rt_tuse,
  input  logic        D_is_md,
  input  logic        D_eret,
  input  logic [4:0]  E_wr_addr,
  input  logic [1:0]  E_tnew,
  input  logic [4:0]  M_wr_addr,
  input  logic [1:0]  M_tnew,
  input  logic        E_md_start,
  input  logic        E_md_div,
  input  logic        E_mtc0_epc,
  input  logic        M_mtc0_epc,
  input  logic        int_req,
  output logic        stall,
  output logic        pc_en,
  output logic        fd_wren,
  output logic        de_stall,
  output logic        req,
  output logic        md_busy,
  output logic        md_done,
  output logic [31:0] stall_cnt
);

  logic        rs_hz, rt_hz, md_hz, eret_hz;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  pipe_hazard_ctrl_md_busy_timer #(
    .MULT_CYC (MULT_CYC),
    .DIV_CYC  (DIV_CYC),
    .CNT_W    (CNT_W)
  ) u_md (
    .clk     (clk),
    .rst_n   (reset),
    .start_i (E_md_start),
    .div_i   (E_md_div),
    .kill_i  (int_req),
    .busy_o  (md_busy),
    .done_o  (md_done)
  );

  always_comb begin
    rs_hz = raw_hit(D_rs_addr, D_rs_tuse,
                    E_wr_addr, E_tnew,
                    M_wr_addr, M_tnew);
    rt_hz = raw_hit(D_rt_addr, D_rt_tuse,
                    E_wr_addr, E_tnew,
                    M_wr_addr, M_tnew);
    md_hz   = D_is_md && (md_busy || E_md_start);
    eret_hz = D_eret && (E_mtc0_epc || M_mtc0_epc);
    // exception flushes everything, so holding would be pointless
    stall    = (rs_hz || rt_hz || md_hz || eret_hz) && !int_req;
    pc_en    = !stall;
    fd_wren  = !stall;
    de_stall = stall;
    req      = int_req;
    stall_cnt_d = stall_cnt_q + {31'd0, stall};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) stall_cnt_q <= '0;
    else        stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage MIPS pipeline.
- Decides each cycle whether PC, F/D and D/E registers advance, hold or take a bubble.
- Tracks the multi-cycle mult/div unit with a busy counter and broadcasts the CP0 exception request to all pipeline registers.
- Keeps a stall-cycle performance counter.
- Sits beside the datapath; drives WrEn/Stall/Req of the inter-stage registers.

Parameters:
- MULT_CYC, 5, busy cycles for mult/multu after the E-stage start cycle.
- DIV_CYC, 10, busy cycles for div/divu after the E-stage start cycle.
- CNT_W, 4, width of the mult/div busy counter; must hold max(MULT_CYC, DIV_CYC).

Ports:
- clk  in  1  pipeline clock.
- reset  in  1  asynchronous, active-low reset.
- D_rs_addr  in  5  rs register index of the instruction in D.
- D_rt_addr  in  5  rt register index of the instruction in D.
- D_rs_tuse  in  2  cycles until D needs rs (3 = not used).
- D_rt_tuse  in  2  cycles until D needs rt (3 = not used).
- D_is_md  in  1  D instruction is mult/div/mfhi/mflo/mthi/mtlo.
- D_eret  in  1  D instruction is eret.
- E_wr_addr  in  5  GPR destination of the E instruction (0 = none).
- E_tnew  in  2  cycles until the E result is ready.
- M_wr_addr  in  5  GPR destination of the M instruction.
- M_tnew  in  2  cycles until the M result is ready.
- E_md_start  in  1  E instruction launches mult/div this cycle.
- E_md_div  in  1  1 = div type, 0 = mult type (qualified by E_md_start).
- E_mtc0_epc  in  1  E instruction is mtc0 to EPC.
- M_mtc0_epc  in  1  M instruction is mtc0 to EPC.
- int_req  in  1  CP0 exception/interrupt request this cycle.
- stall  out  1  combined stall.
- pc_en  out  1  PC write enable.
- fd_wren  out  1  F/D register write enable.
- de_stall  out  1  D/E Stall input (bubble that keeps PC/DelaySlot).
- req  out  1  Req broadcast to all pipeline registers.
- md_busy  out  1  mult/div unit busy.
- md_done  out  1  one-cycle pulse on the final busy cycle.
- stall_cnt  out  32  count of stalled cycles since reset.

Behaviour:
- Data hazard, rs: D_rs_addr != 0 and either of:
  - D_rs_addr == E_wr_addr and E_tnew > D_rs_tuse;
  - D_rs_addr == M_wr_addr and M_tnew > D_rs_tuse.
- Data hazard, rt: same rule using D_rt_addr and D_rt_tuse.
- MD hazard: D_is_md and (md_busy or E_md_start).
- ERET hazard: D_eret and (E_mtc0_epc or M_mtc0_epc).
- stall = OR of all hazards, forced 0 when req = 1.
- Combinational outputs, same cycle as inputs: stall, pc_en = ~stall, fd_wren = ~stall, de_stall = stall, req = int_req.
- MD counter states:
  - IDLE: md_busy = 0. On E_md_start & ~int_req, load cnt = E_md_div ? DIV_CYC : MULT_CYC and go to BUSY at the next edge.
  - BUSY: md_busy = 1; cnt decrements every cycle. md_done is asserted combinationally while cnt == 1; at that edge return to IDLE.
- An exception does not abort an in-flight BUSY count.
- E_md_start while BUSY is illegal: ignore it and keep counting; the bench asserts it never occurs.
- E_md_start in the same cycle as int_req is discarded; the instruction is cancelled.
- stall_cnt increments at each edge where stall = 1 and wraps 0xFFFFFFFF -> 0.
- Reset (asynchronous, any time, including mid-count): state IDLE, cnt = 0, stall_cnt = 0, md_busy = 0, md_done = 0.
- Combinational outputs follow their inputs during reset.

Decomposition:
- Shared package def.v (constants): TUSE_NONE = 2'd3, MULT_CYC, DIV_CYC defaults, state encodings IDLE/BUSY.
- Sub-module md_busy_timer holds the counter and FSM (md_busy, md_done).
- The hazard OR-logic stays in pipe_hazard_ctrl.

Test Plan:
- Load-use: E_wr_addr = 8, E_tnew = 2, D_rs_addr = 8, D_rs_tuse = 1 -> stall = 1, pc_en = 0, de_stall = 1. Next cycle M_wr_addr = 8, M_tnew = 1 -> stall = 0; stall_cnt = 1.
- $0 immunity: D_rs_addr = 0 = E_wr_addr, E_tnew = 2, D_rs_tuse = 0 -> stall = 0.
- Mult: E_md_start = 1, E_md_div = 0 at cycle t.
  - md_busy = 1 for cycles t+1..t+5; md_done high only in t+5.
  - D mflo during t+1..t+5 -> stall = 1; at t+6 -> stall = 0.
- Div: md_busy lasts 10 cycles. Assert reset low at busy cycle 4 -> md_busy = 0 immediately, stall_cnt = 0.
- Exception priority: int_req = 1 with a concurrent RAW hazard and E_md_start = 1 -> req = 1, stall = 0, md_busy stays 0 next cycle.
- ERET: D_eret = 1, M_mtc0_epc = 1 -> stall = 1. Next cycle with no mtc0 in E/M -> stall = 0.
